// File: rtl/oserdes_sched_pkg.sv
// Shared types and default words for the OSERDES start-up and packet scheduler.
package oserdes_sched_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_SRST,
        ST_TRAIN,
        ST_IDLE,
        ST_SEND
    } state_e;

    localparam logic [7:0] TRAIN_WORD_DEF = 8'h55;
    localparam logic [7:0] IDLE_WORD_DEF  = 8'hCA;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/oserdes_sched.sv
// Serializer bring-up sequencer plus round-robin packet scheduler
// feeding an 8:1 OSERDES parallel word.
module oserdes_sched
    import oserdes_sched_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned TRAIN_WORDS = 16,
    parameter logic [7:0]  TRAIN_WORD  = TRAIN_WORD_DEF,
    parameter logic [7:0]  IDLE_WORD   = IDLE_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       serdes_rst,
    output logic       serdes_oce,
    output logic [7:0] serdes_d,
    output logic [1:0] grant,
    output logic [7:0] underrun_cnt
);

    localparam int unsigned CNT_MAX =
        (RST_CYCLES > TRAIN_WORDS) ? RST_CYCLES : TRAIN_WORDS;
    localparam int CW = $clog2(CNT_MAX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          rr_q, rr_d;
    logic [7:0]    ucnt_q, ucnt_d;
    logic [7:0]    d_q, d_d;
    logic          rst_q, oce_q;
    logic          locked_s;
    logic          in_send;
    logic          sel_valid, sel_last;
    logic [7:0]    sel_data;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    assign in_send    = (state_q == ST_SEND);
    assign req0_ready = in_send & grant_q[0];
    assign req1_ready = in_send & grant_q[1];
    assign sel_valid  = grant_q[0] ? req0_valid : (grant_q[1] & req1_valid);
    assign sel_data   = grant_q[0] ? req0_data : req1_data;
    assign sel_last   = grant_q[0] ? req0_last : req1_last;

    // rr_q set means req1 owned the last packet, so req0 wins the next tie
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        ucnt_d  = ucnt_q;
        d_d     = IDLE_WORD;
        if (state_q != ST_WAIT_LOCK && !locked_s) begin
            state_d = ST_WAIT_LOCK;
            grant_d = 2'b00;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_SRST;
                        cnt_d   = CW'(RST_CYCLES - 1);
                    end
                end
                ST_SRST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_TRAIN;
                        cnt_d   = CW'(TRAIN_WORDS - 1);
                        d_d     = TRAIN_WORD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_TRAIN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        d_d   = TRAIN_WORD;
                    end
                end
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state_d = ST_SEND;
                        if (req0_valid && (!req1_valid || rr_q)) begin
                            grant_d = 2'b01;
                            rr_d    = 1'b0;
                        end else begin
                            grant_d = 2'b10;
                            rr_d    = 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (sel_valid) begin
                        d_d = sel_data;
                        if (sel_last) begin
                            state_d = ST_IDLE;
                            grant_d = 2'b00;
                        end
                    end else if (ucnt_q != 8'hFF) begin
                        ucnt_d = ucnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    grant_d = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            grant_q <= 2'b00;
            rr_q    <= 1'b1;
            ucnt_q  <= 8'd0;
            d_q     <= IDLE_WORD;
            rst_q   <= 1'b1;
            oce_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            ucnt_q  <= ucnt_d;
            d_q     <= d_d;
            rst_q   <= (state_d == ST_WAIT_LOCK) || (state_d == ST_SRST);
            oce_q   <= (state_d == ST_TRAIN) || (state_d == ST_IDLE) ||
                       (state_d == ST_SEND);
        end
    end

    assign serdes_rst   = rst_q;
    assign serdes_oce   = oce_q;
    assign serdes_d     = d_q;
    assign grant        = grant_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_oserdes_sched.sv
// Directed bench for oserdes_sched with a cycle-level reference model.
module tb_oserdes_sched;

    localparam int        RSTC = 4;
    localparam int        TRNW = 16;
    localparam logic [7:0] TW  = 8'h55;
    localparam logic [7:0] IW  = 8'hCA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req0_valid = 1'b0, req0_last = 1'b0;
    logic       req1_valid = 1'b0, req1_last = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       serdes_rst, serdes_oce;
    logic [7:0] serdes_d;
    logic [1:0] grant;
    logic [7:0] underrun_cnt;

    oserdes_sched dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_last    (req0_last),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_last    (req1_last),
        .req1_ready   (req1_ready),
        .serdes_rst   (serdes_rst),
        .serdes_oce   (serdes_oce),
        .serdes_d     (serdes_d),
        .grant        (grant),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word streams: v=0 entries are deliberate bubbles while granted
    typedef struct packed {
        logic       v;
        logic       l;
        logic [7:0] d;
    } wd_t;

    wd_t q0[$];
    wd_t q1[$];

    initial forever begin
        @(posedge clk);
        if (q0.size() > 0 && req0_ready && (req0_valid || !q0[0].v))
            void'(q0.pop_front());
        #1;
        if (q0.size() > 0) begin
            req0_valid = q0[0].v;
            req0_data  = q0[0].d;
            req0_last  = q0[0].l;
        end else begin
            req0_valid = 1'b0;
            req0_data  = 8'h00;
            req0_last  = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        if (q1.size() > 0 && req1_ready && (req1_valid || !q1[0].v))
            void'(q1.pop_front());
        #1;
        if (q1.size() > 0) begin
            req1_valid = q1[0].v;
            req1_data  = q1[0].d;
            req1_last  = q1[0].l;
        end else begin
            req1_valid = 1'b0;
            req1_data  = 8'h00;
            req1_last  = 1'b0;
        end
    end

    // Reference model: phase 0 wait-lock, 1 serdes reset, 2 training,
    // 3 idle, 4 sending; 'left' counts cycles still owed in the phase.
    int         ph, left, mg, pref, mu;
    logic [7:0] md;
    logic       s1, s2, ls;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; left = 0; mg = 0; pref = 0; mu = 0;
            md = IW; s1 = 1'b0; s2 = 1'b0;
        end else begin
            ls = s2;
            s2 = s1;
            s1 = pll_locked;
            md = IW;
            if (ph != 0 && !ls) begin
                ph = 0;
                mg = 0;
            end else begin
                case (ph)
                    0: if (ls) begin ph = 1; left = RSTC; end
                    1: begin
                        left--;
                        if (left == 0) begin ph = 2; left = TRNW; md = TW; end
                    end
                    2: begin
                        left--;
                        if (left == 0) ph = 3;
                        else md = TW;
                    end
                    3: if (req0_valid || req1_valid) begin
                        if (req0_valid && req1_valid) mg = 1 << pref;
                        else mg = req0_valid ? 1 : 2;
                        pref = (mg == 1) ? 1 : 0;
                        ph = 4;
                    end
                    default: begin
                        if (mg == 1 ? req0_valid : req1_valid) begin
                            md = (mg == 1) ? req0_data : req1_data;
                            if (mg == 1 ? req0_last : req1_last) begin
                                ph = 3;
                                mg = 0;
                            end
                        end else begin
                            mu = (mu < 255) ? mu + 1 : 255;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("serdes_d", serdes_d, md);
            chk("serdes_rst", serdes_rst, ph < 2);
            chk("serdes_oce", serdes_oce, ph >= 2);
            chk("grant", grant, mg);
            chk("req0_ready", req0_ready, ph == 4 && mg == 1);
            chk("req1_ready", req1_ready, ph == 4 && mg == 2);
            chk("underrun_cnt", underrun_cnt, mu);
        end
    end

    // Log of data words (anything but idle/training) with cycle stamps
    int         cyc = 0;
    logic [7:0] dlog[$];
    int         dcyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst && serdes_oce && serdes_d != IW && serdes_d != TW) begin
            dlog.push_back(serdes_d);
            dcyc.push_back(cyc);
        end
    end

    task automatic lock_and_train();
        int n;
        pll_locked = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (serdes_rst !== 1'b0 && n < 40);
        chk("lock_to_rst_fall", n, 7);
        n = 0;
        while (serdes_d === TW && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("train_words", n, TRNW);
        chk("post_train_d", serdes_d, IW);
        chk("post_train_oce", serdes_oce, 1);
    endtask

    task automatic bringup();
        @(negedge clk);
        pll_locked = 1'b0;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        lock_and_train();
        dlog.delete();
        dcyc.delete();
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || grant !== 2'b00) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n >= 2000) begin
            n_bad++;
            $display("FAIL %s: timeout, %0d words still queued", nm, q0.size() + q1.size());
        end
    endtask

    function automatic wd_t w(input logic [7:0] d, input logic l);
        return '{v: 1'b1, l: l, d: d};
    endfunction

    localparam wd_t BUB = '{v: 1'b0, l: 1'b0, d: 8'h00};

    logic [1:0] gseq[$];

    initial begin
        int n;
        logic [1:0] gprev;

        repeat (3) @(negedge clk);
        chk("rst_serdes_rst", serdes_rst, 1);
        chk("rst_oce", serdes_oce, 0);
        chk("rst_d", serdes_d, IW);
        chk("rst_grant", grant, 0);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_ready0", req0_ready, 0);

        bringup();
        q0.push_back(w(8'h01, 1'b0));
        q0.push_back(w(8'h02, 1'b0));
        q0.push_back(w(8'h03, 1'b1));
        wait_done("single");
        chk("single_len", dlog.size(), 3);
        if (dlog.size() == 3) begin
            chk("single_w0", dlog[0], 8'h01);
            chk("single_w1", dlog[1], 8'h02);
            chk("single_w2", dlog[2], 8'h03);
            chk("single_consec", dcyc[2] - dcyc[0], 2);
        end
        chk("single_grant_end", grant, 0);

        bringup();
        for (int p = 0; p < 4; p++) begin
            q0.push_back(w(8'hA0 + 8'(p), 1'b0));
            q0.push_back(w(8'hB0 + 8'(p), 1'b1));
            q1.push_back(w(8'hC0 + 8'(p), 1'b0));
            q1.push_back(w(8'hD0 + 8'(p), 1'b1));
        end
        gseq.delete();
        gprev = 2'b00;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || grant != 2'b00) && n < 200) begin
            @(negedge clk);
            n++;
            if (grant != gprev && grant != 2'b00) gseq.push_back(grant);
            gprev = grant;
        end
        chk("fair_npkts", gseq.size(), 8);
        if (gseq.size() >= 4) begin
            chk("fair_g0", gseq[0], 2'b01);
            chk("fair_g1", gseq[1], 2'b10);
            chk("fair_g2", gseq[2], 2'b01);
            chk("fair_g3", gseq[3], 2'b10);
        end

        bringup();
        q1.push_back(w(8'h11, 1'b0));
        q1.push_back(w(8'h12, 1'b0));
        repeat (3) q1.push_back(BUB);
        q1.push_back(w(8'h13, 1'b1));
        wait_done("underrun");
        chk("under_cnt", underrun_cnt, 3);
        chk("under_len", dlog.size(), 3);
        if (dlog.size() == 3) begin
            chk("under_last", dlog[2], 8'h13);
            chk("under_gap", dcyc[2] - dcyc[1], 4);
        end

        bringup();
        q0.push_back(w(8'h21, 1'b0));
        repeat (300) q0.push_back(BUB);
        q0.push_back(w(8'h22, 1'b1));
        wait_done("saturate");
        chk("sat_cnt", underrun_cnt, 255);

        bringup();
        for (int i = 0; i < 10; i++)
            q0.push_back(w(8'h31 + 8'(i), i == 9));
        n = 0;
        while (dlog.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lol_started", dlog.size() >= 2, 1);
        pll_locked = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req0_ready === 1'b0 && serdes_rst === 1'b1) && n < 10);
        chk("lol_within_3", n <= 3, 1);
        q0.delete();
        repeat (5) @(negedge clk);
        chk("lol_ready0", req0_ready, 0);
        chk("lol_grant", grant, 0);
        chk("lol_oce", serdes_oce, 0);
        lock_and_train();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oserdes_sched.md
OSERDES_SCHED -- requirements
Module: oserdes_sched

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 4, the number of clk cycles serdes_rst is held high after lock.
REQ-002 The block SHALL have parameter TRAIN_WORDS, default 16, the number of training words sent after serializer reset.
REQ-003 The block SHALL have parameter TRAIN_WORD, default 8'h55, the training pattern.
REQ-004 The block SHALL have parameter IDLE_WORD, default 8'hCA, the word sent when no data is available.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, the serializer CLKDIV domain; reset is asynchronous and active-high.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port pll_locked, input, 1 bit: PLL lock, asynchronous to clk.
REQ-008 The block SHALL have ports reqN_valid (input, 1), reqN_data (input, 8), reqN_last (input, 1) and reqN_ready (output, 1), for N=0,1: word streams.
REQ-009 The block SHALL have port serdes_rst, output, 1 bit: serializer RST.
REQ-010 The block SHALL have port serdes_oce, output, 1 bit: serializer OCE.
REQ-011 The block SHALL have port serdes_d, output, 8 bits: parallel word; bit0 drives D1 and is serialized first.
REQ-012 The block SHALL have port grant, output, 2 bits: one-hot owner of the current packet, 0 when none.
REQ-013 The block SHALL have port underrun_cnt, output, 8 bits: saturating count of underrun words.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; locked_s denotes its output.
REQ-015 The FSM SHALL have states WAIT_LOCK, SRST, TRAIN, IDLE and SEND.
REQ-016 WAIT_LOCK SHALL drive serdes_rst=1 and serdes_oce=0; it SHALL go to SRST when locked_s=1.
REQ-017 SRST SHALL hold serdes_rst=1 for exactly RST_CYCLES cycles, then go to TRAIN.
REQ-018 TRAIN SHALL drive serdes_rst=0, serdes_oce=1 and serdes_d=TRAIN_WORD for exactly TRAIN_WORDS cycles, then go to IDLE.
REQ-019 IDLE SHALL drive serdes_d=IDLE_WORD and grant=0.
REQ-020 In IDLE, when any reqN_valid=1, the block SHALL grant the requester for the next cycle, go to SEND and accept no word in the granting cycle.
REQ-021 Arbitration SHALL be round-robin at packet granularity: on a tie, the requester not granted last wins; after reset, req0 wins the first tie.
REQ-022 reqN_ready SHALL equal (state==SEND and grant[N]) and SHALL depend on registers only.
REQ-023 A word SHALL be accepted when valid and ready are both 1; serdes_d SHALL show it on the next cycle, so latency is 1 clk.
REQ-024 In SEND with granted valid=0, serdes_d SHALL be IDLE_WORD and underrun_cnt SHALL increment, saturating at 255.
REQ-025 Accepting a word with last=1 SHALL return the FSM to IDLE and clear grant on the next cycle.
REQ-026 A non-granted requester SHALL never see ready=1, and its valid SHALL not affect serdes_d.
REQ-027 In any state past WAIT_LOCK, locked_s=0 SHALL force WAIT_LOCK on the next cycle, with serdes_rst=1, oce=0, grant=0 and readies=0; a packet in flight is abandoned.
REQ-028 The lock-loss transition SHALL take priority over every other transition in the same cycle, including acceptance of a last word.
REQ-029 serdes_d, serdes_rst and serdes_oce SHALL be registered outputs.

Reset
REQ-030 On rst the block SHALL set state=WAIT_LOCK, serdes_rst=1, serdes_oce=0, serdes_d=IDLE_WORD and grant=0.
REQ-031 On rst the block SHALL clear the round-robin pointer (to req0 preference), underrun_cnt, all counters and the synchronizer flops.
REQ-032 Reset mid-packet SHALL drop the packet with no further ready assertion.

Structure
REQ-033 A shared package SHALL hold the state enum and the TRAIN_WORD/IDLE_WORD defaults.
REQ-034 The 2-flop synchronizer SHALL be the single sub-module, named sync_2ff.
REQ-035 A single shared down-counter SHALL time both SRST and TRAIN.

Verification
REQ-036 Startup: release rst, raise pll_locked at cycle 10 -> serdes_rst falls after 2 sync cycles plus 4 clk; then 16 words of 8'h55; then 8'hCA.
REQ-037 Single packet: req0 sends 3 words 8'h01, 8'h02, 8'h03 with last on 8'h03 -> serdes_d shows 01, 02, 03 on consecutive cycles; grant returns to 0.
REQ-038 Fairness: req0 and req1 both valid continuously with 2-word packets -> grants alternate 01, 10, 01, 10; req0 is first.
REQ-039 Underrun: req1 granted, valid drops for 3 cycles mid-packet -> 3 cycles of 8'hCA; underrun_cnt=3; packet then completes.
REQ-040 Lock loss: pll_locked drops during SEND -> ready=0 and serdes_rst=1 within 3 clk; full SRST/TRAIN sequence replays after relock.
REQ-041 Saturation: 300 underrun cycles -> underrun_cnt=255.
